// File: rtl/puf_pkg.sv
// Shared definitions for the PUF evaluation controller: default width,
// controller state encoding and the vote-counter sizing rule.
package puf_pkg;

  localparam int C_LENGTH_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    PULSE_LO = 3'd2,
    PULSE_HI = 3'd3,
    SAMPLE   = 3'd4,
    DONE     = 3'd5
  } state_t;

  // Width of a counter that must hold values 0..n_eval inclusive.
  function automatic int vote_cnt_width(input int n_eval);
    return $clog2(n_eval + 1);
  endfunction

endpackage

// File: rtl/puf_vote_cnt.sv
// One response bit: 2-flop synchroniser for the asynchronous arbiter output,
// a ones counter over the evaluations of a request, and the registered
// majority / stability flags produced on the final sample.
module puf_vote_cnt
  import puf_pkg::*;
#(
  parameter int N_EVAL = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  input  logic clr,
  input  logic add,
  input  logic fin,
  output logic maj,
  output logic stable
);

  localparam int CW = vote_cnt_width(N_EVAL);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] ones;
  logic [CW-1:0] ones_next;

  // Count including the sample being taken this cycle, so the flags can be
  // registered on the same edge as the last sample.
  assign ones_next = ones + CW'(sync2);

  // Two-stage synchroniser; raw changes with no relation to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make sync2 take the old sync1, giving
      // two real flop stages; blocking here would collapse them into one.
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Ones counter plus result flags; flags hold until the next final sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones   <= '0;
      maj    <= 1'b0;
      stable <= 1'b0;
    end else begin
      if (clr) begin
        ones <= '0;
      end else if (add) begin
        ones <= ones_next;
      end
      if (fin) begin
        maj    <= (ones_next > CW'(N_EVAL / 2));
        stable <= (ones_next == '0) || (ones_next == CW'(N_EVAL));
      end
    end
  end

endmodule

// File: rtl/puf_eval_ctrl.sv
// Evaluation controller for the arbiter PUF array: latches a challenge,
// generates N_EVAL race pulses in the clk domain, and majority-votes the
// synchronised response bits into a response word and a stability mask.
module puf_eval_ctrl
  import puf_pkg::*;
#(
  parameter int C_LENGTH   = C_LENGTH_DEFAULT,
  parameter int N_EVAL     = 7,
  parameter int SETTLE_CYC = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [C_LENGTH-1:0] challenge_in,
  output logic                busy,
  output logic [C_LENGTH-1:0] puf_challenge,
  output logic                puf_pulse,
  input  logic [C_LENGTH-1:0] puf_response,
  output logic [C_LENGTH-1:0] resp_out,
  output logic [C_LENGTH-1:0] stable_mask,
  output logic                resp_valid
);

  // Reject unusable parameterisations at elaboration time.
  if (N_EVAL < 1 || N_EVAL > 15 || (N_EVAL % 2) == 0) begin : g_bad_n_eval
    $error("puf_eval_ctrl: N_EVAL must be odd and within 1..15");
  end
  if (SETTLE_CYC < 3 || SETTLE_CYC > 255) begin : g_bad_settle
    $error("puf_eval_ctrl: SETTLE_CYC must be within 3..255");
  end

  localparam int EW = vote_cnt_width(N_EVAL);

  state_t        state;
  logic [EW-1:0] eval_cnt;
  logic [7:0]    phase_cnt;
  logic          last_eval;
  logic          phase_end;
  logic          vote_clr;
  logic          vote_add;
  logic          vote_fin;

  assign last_eval = (eval_cnt == EW'(N_EVAL - 1));
  assign phase_end = (phase_cnt == 8'(SETTLE_CYC - 1));
  assign vote_clr  = (state == LOAD);
  assign vote_add  = (state == SAMPLE);
  assign vote_fin  = vote_add && last_eval;

  // Request sequencer: challenge latch, pulse phases, evaluation count and
  // the registered busy / pulse / valid outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      puf_challenge <= '0;
      puf_pulse     <= 1'b0;
      busy          <= 1'b0;
      resp_valid    <= 1'b0;
      eval_cnt      <= '0;
      phase_cnt     <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            puf_challenge <= challenge_in;
            busy          <= 1'b1;
            state         <= LOAD;
          end
        end
        LOAD: begin
          eval_cnt  <= '0;
          phase_cnt <= '0;
          state     <= PULSE_LO;
        end
        PULSE_LO: begin
          if (phase_end) begin
            phase_cnt <= '0;
            puf_pulse <= 1'b1;
            state     <= PULSE_HI;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end
        PULSE_HI: begin
          if (phase_end) begin
            phase_cnt <= '0;
            state     <= SAMPLE;
          end else begin
            phase_cnt <= phase_cnt + 8'd1;
          end
        end
        SAMPLE: begin
          puf_pulse <= 1'b0;
          if (last_eval) begin
            resp_valid <= 1'b1;
            state      <= DONE;
          end else begin
            eval_cnt <= eval_cnt + EW'(1);
            state    <= PULSE_LO;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One synchroniser and vote counter per response bit.
  for (genvar i = 0; i < C_LENGTH; i++) begin : g_bit
    puf_vote_cnt #(
      .N_EVAL (N_EVAL)
    ) u_vote (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (puf_response[i]),
      .clr    (vote_clr),
      .add    (vote_add),
      .fin    (vote_fin),
      .maj    (resp_out[i]),
      .stable (stable_mask[i])
    );
  end

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench for puf_eval_ctrl: table-driven response patterns on
// the default configuration, hand sequences for ignored starts, mid-request
// reset, and a second instance with N_EVAL=1, SETTLE_CYC=3.
module tb_puf_eval_ctrl;

  localparam int DONE_CYC = 65;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] challenge_in;
  logic       busy;
  logic [7:0] puf_challenge;
  logic       puf_pulse;
  logic [7:0] puf_response;
  logic [7:0] resp_out;
  logic [7:0] stable_mask;
  logic       resp_valid;

  logic       start1;
  logic [7:0] challenge_in1;
  logic       busy1;
  logic [7:0] puf_challenge1;
  logic       puf_pulse1;
  logic [7:0] puf_response1;
  logic [7:0] resp_out1;
  logic [7:0] stable_mask1;
  logic       resp_valid1;

  always #5 clk = ~clk;

  puf_eval_ctrl u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .challenge_in  (challenge_in),
    .busy          (busy),
    .puf_challenge (puf_challenge),
    .puf_pulse     (puf_pulse),
    .puf_response  (puf_response),
    .resp_out      (resp_out),
    .stable_mask   (stable_mask),
    .resp_valid    (resp_valid)
  );

  puf_eval_ctrl #(
    .C_LENGTH   (8),
    .N_EVAL     (1),
    .SETTLE_CYC (3)
  ) u_dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start1),
    .challenge_in  (challenge_in1),
    .busy          (busy1),
    .puf_challenge (puf_challenge1),
    .puf_pulse     (puf_pulse1),
    .puf_response  (puf_response1),
    .resp_out      (resp_out1),
    .stable_mask   (stable_mask1),
    .resp_valid    (resp_valid1)
  );

  typedef struct packed {
    logic [7:0]      chal;
    logic [6:0][7:0] pat;       // pat[k] = response during evaluation k
    logic [7:0]      exp_resp;
    logic [7:0]      exp_mask;
  } vec_t;

  vec_t vecs [5];

  int errors = 0;
  int checks = 0;

  int         valid_cnt;
  int         valid_cyc;
  int         rise_cnt;
  int         busy_err;
  int         pulse_err;
  int         chal_err;
  int         x_err;
  logic [7:0] cap_resp;
  logic [7:0] cap_mask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one request on the default instance. Called in cycle 0; start is
  // sampled on the following edge. Observes cycles 1..last.
  task automatic run_req(input logic [7:0] chal, input logic [6:0][7:0] pat,
                         input int ign_a, input int ign_b, input int rst_cyc,
                         input int last);
    logic prev_pulse;
    logic exp_pulse;
    bit   live;
    valid_cnt = 0; valid_cyc = -1; rise_cnt = 0;
    busy_err = 0; pulse_err = 0; chal_err = 0; x_err = 0;
    cap_resp = 8'h00; cap_mask = 8'h00;
    challenge_in = chal;
    puf_response = pat[0];
    start = 1'b1;
    prev_pulse = 1'b0;
    for (int n = 1; n <= last; n++) begin
      @(posedge clk); #1;
      live = (rst_cyc == 0) || (n < rst_cyc);
      start = (n == ign_a) || (n == ign_b);
      challenge_in = ~chal;
      if (rst_cyc != 0 && n == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_pulse", puf_pulse, 1'b0);
        check("rst_resp_out", resp_out, 8'h00);
        check("rst_mask", stable_mask, 8'h00);
      end
      if (rst_cyc != 0 && n == rst_cyc + 1) rst_n = 1'b1;
      if (resp_valid === 1'b1) begin
        valid_cnt++;
        valid_cyc = n;
        cap_resp = resp_out;
        cap_mask = stable_mask;
      end
      if ($isunknown({resp_out, stable_mask, resp_valid})) x_err++;
      if (live) begin
        if (busy !== (n <= DONE_CYC)) busy_err++;
        if (puf_challenge !== chal) chal_err++;
        exp_pulse = 1'b0;
        if (n >= 2 && n < DONE_CYC) exp_pulse = (((n - 2) % 9) >= 4);
        if (puf_pulse !== exp_pulse) pulse_err++;
      end
      if (puf_pulse === 1'b1 && prev_pulse === 1'b0) rise_cnt++;
      prev_pulse = puf_pulse;
      // Change the response mid-PULSE_HI at a random offset within the cycle.
      if (live && n >= 7 && ((n - 7) % 9) == 0 && ((n - 7) / 9) < 7) begin
        #($urandom_range(0, 7));
        puf_response = pat[(n - 7) / 9];
      end
    end
  endtask

  task automatic check_run(input string tag, input vec_t v);
    run_req(v.chal, v.pat, 0, 0, 0, DONE_CYC + 1);
    check({tag, "_valid_cnt"}, valid_cnt, 1);
    check({tag, "_valid_cyc"}, valid_cyc, DONE_CYC);
    check({tag, "_resp_out"}, cap_resp, v.exp_resp);
    check({tag, "_stable_mask"}, cap_mask, v.exp_mask);
    check({tag, "_pulse_rises"}, rise_cnt, 7);
    check({tag, "_busy_errs"}, busy_err, 0);
    check({tag, "_pulse_errs"}, pulse_err, 0);
    check({tag, "_chal_errs"}, chal_err, 0);
    check({tag, "_x_errs"}, x_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  got;
    bit  seen;

    rst_n = 1'b0;
    start = 1'b0;
    challenge_in = 8'h00;
    puf_response = 8'h00;
    start1 = 1'b0;
    challenge_in1 = 8'h11;
    puf_response1 = 8'hFF;

    vecs[0] = '{chal: 8'h3C, pat: {7{8'hA5}}, exp_resp: 8'hA5, exp_mask: 8'hFF};
    vecs[1] = '{chal: 8'h81, pat: {8'h02, 8'h02, 8'h02, 8'h01, 8'h01, 8'h01, 8'h01},
                exp_resp: 8'h01, exp_mask: 8'hFC};
    vecs[2] = '{chal: 8'h5A, pat: {8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55},
                exp_resp: 8'h55, exp_mask: 8'h00};
    vecs[3] = '{chal: 8'hE7, pat: {8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF},
                exp_resp: 8'hFF, exp_mask: 8'h0F};
    vecs[4] = '{chal: 8'h00, pat: {7{8'h00}}, exp_resp: 8'h00, exp_mask: 8'hFF};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_pulse", puf_pulse, 1'b0);
    check("reset_challenge", puf_challenge, 8'h00);
    check("reset_resp_out", resp_out, 8'h00);
    check("reset_mask", stable_mask, 8'h00);
    check("reset_valid", resp_valid, 1'b0);
    check("reset_dut1_resp_out", resp_out1, 8'h00);
    check("reset_dut1_busy", busy1, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven response patterns.
    for (int i = 0; i < 5; i++) begin
      check_run($sformatf("vec%0d", i), vecs[i]);
    end

    // Starts in cycles 10 and 65 ignored; start in cycle 66 accepted.
    run_req(8'h3C, {7{8'hA5}}, 10, DONE_CYC, 0, DONE_CYC);
    check("ign_valid_cnt", valid_cnt, 1);
    check("ign_valid_cyc", valid_cyc, DONE_CYC);
    check("ign_busy_errs", busy_err, 0);
    check("ign_chal_errs", chal_err, 0);
    check("ign_resp_out", cap_resp, 8'hA5);
    challenge_in = 8'hC3;
    @(posedge clk); #1;                  // cycle 66, start still high
    check("cyc66_busy", busy, 1'b0);
    @(posedge clk); #1;                  // cycle 67
    start = 1'b0;
    check("cyc67_busy", busy, 1'b1);
    check("cyc67_challenge", puf_challenge, 8'hC3);
    seen = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge clk); #1;
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    check("restart_valid_seen", seen, 1'b1);
    check("restart_resp_out", resp_out, 8'hA5);
    @(posedge clk); #1;

    // Reset asserted in cycle 30 aborts the request.
    run_req(8'h96, {7{8'hFF}}, 0, 0, 30, 70);
    check("abort_valid_cnt", valid_cnt, 0);
    check("abort_busy_errs", busy_err, 0);
    check("abort_chal_errs", chal_err, 0);
    check("abort_pulse_errs", pulse_err, 0);
    check_run("post_reset", vecs[1]);

    // N_EVAL=1, SETTLE_CYC=3 instance: DONE in cycle 9.
    start1 = 1'b1;
    got = -1;
    for (int n = 1; n <= 30 && got < 0; n++) begin
      @(posedge clk); #1;
      start1 = 1'b0;
      if (resp_valid1 === 1'b1) got = n;
    end
    check("dut1_valid_cyc", got, 9);
    check("dut1_resp_out", resp_out1, 8'hFF);
    check("dut1_mask", stable_mask1, 8'hFF);
    check("dut1_challenge", puf_challenge1, 8'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
